memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 212 +++++++++++++++++++++
 tb/tb_memory_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues loads/stores on the data bus, stalls until data_ok, then
// registers the aligned/extended result. Define MEM_MISALIGN_CHECK_EN to trap misaligned accesses.

typedef enum logic [1:0] {Msize1 = 2'd0, Msize2 = 2'd1, Msize4 = 2'd2, Msize8 = 2'd3} msize_t;

typedef struct packed {
  logic   regwrite;
  logic   memread;
  logic   memwrite;
  msize_t memsize;
  logic   zeroextwb;
} control_t;

typedef struct packed {
  logic        valid;
  logic [63:0] pc;
  logic [31:0] raw_instr;
  control_t    ctl;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  dst;
  logic [63:0] aluout;
  logic [63:0] memwd;
} execute_data_t;

typedef struct packed {
  logic        valid;
  logic [63:0] pc;
  logic [31:0] raw_instr;
  control_t    ctl;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  dst;
  logic [63:0] writedata;
  logic [63:0] memaddr;
} memory_data_t;

typedef struct packed {
  logic        valid;
  logic [63:0] addr;
  msize_t      size;
  logic [7:0]  strobe;
  logic [63:0] data;
} dbus_req_t;

typedef struct packed {
  logic        addr_ok;
  logic        data_ok;
  logic [63:0] data;
} dbus_resp_t;

module memory_stage (
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  output memory_data_t  dataM,
  output logic          stallM,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output logic          misalignM
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e        state_q, state_d;
  execute_data_t inst_q, inst_d;
  memory_data_t  data_m_q, data_m_d;
  logic          misalign_q, misalign_d;
  logic          mem_op;
  logic          mis;

  // Completion is decided by data_ok alone.
  logic unused_addr_ok;
  assign unused_addr_ok = dresp.addr_ok;

  function automatic logic [7:0] strobe_of(msize_t s, logic [2:0] off);
    logic [7:0] base;
    unique case (s)
      Msize1:  base = 8'h01;
      Msize2:  base = 8'h03;
      Msize4:  base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic dbus_req_t req_of(execute_data_t e);
    dbus_req_t r;
    r.valid  = e.valid & (e.ctl.memread | e.ctl.memwrite);
    r.addr   = e.aluout;
    r.size   = e.ctl.memsize;
    r.strobe = e.ctl.memwrite ? strobe_of(e.ctl.memsize, e.aluout[2:0]) : 8'h00;
    r.data   = e.ctl.memwrite ? (e.memwd << {e.aluout[2:0], 3'b000}) : 64'h0;
    return r;
  endfunction

  function automatic logic [63:0] load_ext(msize_t s, logic zext, logic [63:0] raw,
                                           logic [2:0] off);
    logic [63:0] sh;
    sh = raw >> {off, 3'b000};
    unique case (s)
      Msize1:  return zext ? {56'h0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      Msize2:  return zext ? {48'h0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      Msize4:  return zext ? {32'h0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  function automatic memory_data_t pass_of(execute_data_t e, logic [63:0] wdata);
    memory_data_t m;
    m.valid     = e.valid;
    m.pc        = e.pc;
    m.raw_instr = e.raw_instr;
    m.ctl       = e.ctl;
    m.ra1       = e.ra1;
    m.ra2       = e.ra2;
    m.dst       = e.dst;
    m.writedata = wdata;
    m.memaddr   = e.aluout;
    return m;
  endfunction

  // Store writedata is don't-care; the address is reused.
  function automatic memory_data_t result_of(execute_data_t e, logic [63:0] rdata);
    logic [63:0] wd;
    wd = e.ctl.memread ? load_ext(e.ctl.memsize, e.ctl.zeroextwb, rdata, e.aluout[2:0])
                       : e.aluout;
    return pass_of(e, wd);
  endfunction

  function automatic logic misaligned(msize_t s, logic [2:0] off);
    unique case (s)
      Msize1:  return 1'b0;
      Msize2:  return off[0];
      Msize4:  return |off[1:0];
      default: return |off;
    endcase
  endfunction

  assign mem_op = dataE.valid & (dataE.ctl.memread | dataE.ctl.memwrite);

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = mem_op & misaligned(dataE.ctl.memsize, dataE.aluout[2:0]);
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    data_m_d   = '0;
    misalign_d = 1'b0;
    dreq       = '0;
    stallM     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mis) begin
          data_m_d              = pass_of(dataE, dataE.aluout);
          data_m_d.ctl.regwrite = 1'b0;
          data_m_d.ctl.memwrite = 1'b0;
          misalign_d            = 1'b1;
        end else if (mem_op) begin
          dreq = req_of(dataE);
          if (dresp.data_ok) begin
            data_m_d = result_of(dataE, dresp.data);
          end else begin
            stallM  = 1'b1;
            inst_d  = dataE;
            state_d = StWait;
          end
        end else if (dataE.valid) begin
          data_m_d = pass_of(dataE, dataE.aluout);
        end
      end
      StWait: begin
        dreq   = req_of(inst_q);
        stallM = 1'b1;
        if (dresp.data_ok) begin
          data_m_d = result_of(inst_q, dresp.data);
          state_d  = StDone;
        end
      end
      StDone: begin
        // dataE still shows the finished access this cycle; it must not be reissued.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (reset) begin
      stallM     = 1'b0;
      dreq.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      inst_q     <= '0;
      data_m_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      data_m_q   <= data_m_d;
      misalign_q <= misalign_d;
    end
  end

  assign dataM     = data_m_q;
  assign misalignM = misalign_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected writeback records are queued at issue/completion
// and popped whenever dataM.valid is seen.

module tb_memory_stage;

  logic          clk;
  logic          reset;
  execute_data_t dataE;
  memory_data_t  dataM;
  logic          stallM;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  logic          misalignM;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] wd;
    logic [63:0] addr;
    logic        cmp_wd;
    logic        regwrite;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  memory_stage dut (
    .clk       (clk),
    .reset     (reset),
    .dataE     (dataE),
    .dataM     (dataM),
    .stallM    (stallM),
    .dreq      (dreq),
    .dresp     (dresp),
    .misalignM (misalignM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic execute_data_t mk(logic [63:0] pc, logic rd, logic wr, msize_t sz,
                                       logic zext, logic [63:0] alu, logic [63:0] wd);
    execute_data_t e;
    e               = '0;
    e.valid         = 1'b1;
    e.pc            = pc;
    e.raw_instr     = pc[31:0] ^ 32'h0000_0013;
    e.ctl.regwrite  = rd | ~wr;
    e.ctl.memread   = rd;
    e.ctl.memwrite  = wr;
    e.ctl.memsize   = sz;
    e.ctl.zeroextwb = zext;
    e.ra1           = 5'd1;
    e.ra2           = 5'd2;
    e.dst           = 5'd3;
    e.aluout        = alu;
    e.memwd         = wd;
    return e;
  endfunction

  function automatic exp_t exp_of(execute_data_t e, logic [63:0] wd, logic cmp, logic mis);
    exp_t x;
    x.pc       = e.pc;
    x.wd       = wd;
    x.addr     = e.aluout;
    x.cmp_wd   = cmp;
    x.regwrite = mis ? 1'b0 : e.ctl.regwrite;
    x.mis      = mis;
    return x;
  endfunction

  always @(negedge clk) begin
    if (!reset && dataM.valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_dataM", 64'(dataM.valid), 64'd0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check_eq("sb_pc", dataM.pc, x.pc);
        check_eq("sb_memaddr", dataM.memaddr, x.addr);
        check_eq("sb_regwrite", 64'(dataM.ctl.regwrite), 64'(x.regwrite));
        check_eq("sb_misalign", 64'(misalignM), 64'(x.mis));
        if (x.cmp_wd) check_eq("sb_writedata", dataM.writedata, x.wd);
      end
    end
  end

  // One instruction: drive at posedge+1, check combinational bus at negedge.
  task automatic run_op(input string tag, input execute_data_t e, input int lat,
                        input logic [63:0] rdata, input logic [63:0] exp_wd,
                        input logic [7:0] exp_strb, input logic [63:0] exp_bd);
    bit mem;
    int stalls;
    mem    = e.ctl.memread | e.ctl.memwrite;
    stalls = 0;
    dataE  = e;
    if (!mem) begin
      exp_q.push_back(exp_of(e, exp_wd, 1'b1, 1'b0));
      @(negedge clk);
      check_eq({tag, "_dreq_valid"}, 64'(dreq.valid), 64'd0);
      check_eq({tag, "_stall"}, 64'(stallM), 64'd0);
      @(posedge clk); #1;
      check_eq({tag, "_latency"}, 64'(dataM.valid), 64'd1);
      return;
    end
    for (int k = 1; k <= lat; k++) begin
      dresp.data_ok = (k == lat);
      dresp.addr_ok = 1'($urandom_range(0, 1));
      dresp.data    = (k == lat) ? rdata : {$urandom, $urandom};
      if (k == lat) exp_q.push_back(exp_of(e, exp_wd, e.ctl.memread, 1'b0));
      @(negedge clk);
      check_eq({tag, "_dreq_valid"}, 64'(dreq.valid), 64'd1);
      check_eq({tag, "_dreq_addr"}, dreq.addr, e.aluout);
      check_eq({tag, "_dreq_size"}, 64'(dreq.size), 64'(e.ctl.memsize));
      check_eq({tag, "_dreq_strobe"}, 64'(dreq.strobe), 64'(exp_strb));
      if (e.ctl.memwrite) check_eq({tag, "_dreq_data"}, dreq.data, exp_bd);
      if (k >= 2) check_eq({tag, "_bubble"}, 64'(dataM.valid), 64'd0);
      stalls += int'(stallM);
      @(posedge clk); #1;
    end
    dresp.data_ok = 1'b0;
    check_eq({tag, "_latency"}, 64'(dataM.valid), 64'd1);
    check_eq({tag, "_stall_cycles"}, 64'(stalls), 64'(lat > 1 ? lat : 0));
    if (lat > 1) begin
      @(negedge clk);
      check_eq({tag, "_done_dreq"}, 64'(dreq.valid), 64'd0);
      check_eq({tag, "_done_stall"}, 64'(stallM), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    execute_data_t e;
    dataE = '0;
    dresp = '0;
    reset = 1'b1;
    #12;
    check_eq("rst_dataM_valid", 64'(dataM.valid), 64'd0);
    check_eq("rst_dataM_zero", 64'(dataM.writedata | dataM.pc), 64'd0);
    check_eq("rst_stall", 64'(stallM), 64'd0);
    check_eq("rst_dreq", 64'(dreq.valid), 64'd0);
    check_eq("rst_misalign", 64'(misalignM), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("ld", mk(64'h100, 1, 0, Msize8, 0, 64'h8000_1000, 0), 3,
           64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 8'h00, 0);
    run_op("lb", mk(64'h104, 1, 0, Msize1, 0, 64'h8000_1003, 0), 1,
           64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 0);
    run_op("lbu", mk(64'h108, 1, 0, Msize1, 1, 64'h8000_1003, 0), 2,
           64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, 8'h00, 0);
    run_op("sh", mk(64'h10C, 0, 1, Msize2, 0, 64'h8000_1006, 64'hABCD), 1,
           0, 0, 8'hC0, 64'hABCD_0000_0000_0000);
    run_op("add", mk(64'h110, 0, 0, Msize8, 0, 64'h5, 0), 0, 0, 64'h5, 8'h00, 0);
    run_op("lh", mk(64'h114, 1, 0, Msize2, 0, 64'h8000_1002, 0), 4,
           64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001, 8'h00, 0);
    run_op("lwu", mk(64'h118, 1, 0, Msize4, 1, 64'h8000_1004, 0), 1,
           64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF, 8'h00, 0);
    run_op("sb", mk(64'h11C, 0, 1, Msize1, 0, 64'h8000_1005, 64'h5A), 2,
           0, 0, 8'h20, 64'h0000_5A00_0000_0000);
    run_op("sd", mk(64'h120, 0, 1, Msize8, 0, 64'h8000_1008, 64'h0123_4567_89AB_CDEF), 1,
           0, 0, 8'hFF, 64'h0123_4567_89AB_CDEF);
    run_op("sub", mk(64'h124, 0, 0, Msize8, 0, 64'hFFFF_0000_1234_0000, 0), 0, 0,
           64'hFFFF_0000_1234_0000, 8'h00, 0);

    e = mk(64'h128, 1, 0, Msize4, 0, 64'h8000_1002, 0);
`ifdef MEM_MISALIGN_CHECK_EN
    dataE = e;
    exp_q.push_back(exp_of(e, 0, 1'b0, 1'b1));
    @(negedge clk);
    check_eq("mis_dreq", 64'(dreq.valid), 64'd0);
    check_eq("mis_stall", 64'(stallM), 64'd0);
    @(posedge clk); #1;
    check_eq("mis_flag", 64'(misalignM), 64'd1);
    check_eq("mis_valid", 64'(dataM.valid), 64'd1);
    check_eq("mis_regwrite", 64'(dataM.ctl.regwrite), 64'd0);
`else
    run_op("lw_mis", e, 1, 64'h1122_3344_5566_7788, 64'h0000_0000_3344_5566, 8'h00, 0);
    check_eq("nomis_flag", 64'(misalignM), 64'd0);
`endif

    // Reset while waiting: the late response must be dropped.
    dataE = mk(64'h12C, 1, 0, Msize8, 0, 64'h8000_1010, 0);
    dresp.data_ok = 1'b0;
    @(negedge clk);
    check_eq("rw_stall_idle", 64'(stallM), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rw_stall_wait", 64'(stallM), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rw_stall", 64'(stallM), 64'd0);
    check_eq("rw_dreq", 64'(dreq.valid), 64'd0);
    check_eq("rw_dataM", 64'(dataM.valid), 64'd0);
    check_eq("rw_misalign", 64'(misalignM), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dataE = '0;
    @(posedge clk); #1;
    dresp.data_ok = 1'b1;
    dresp.data    = 64'hDEAD_DEAD_DEAD_DEAD;
    @(negedge clk);
    check_eq("late_dreq", 64'(dreq.valid), 64'd0);
    check_eq("late_stall", 64'(stallM), 64'd0);
    @(posedge clk); #1;
    dresp.data_ok = 1'b0;
    check_eq("late_dataM", 64'(dataM.valid), 64'd0);

    run_op("add2", mk(64'h130, 0, 0, Msize8, 0, 64'h77, 0), 0, 0, 64'h77, 8'h00, 0);
    dataE = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
